// File: rtl/ps2_device.sv
// PS/2 device-side link controller: generates the PS/2 clock, sends device-to-host
// frames and receives and acknowledges host-to-device command bytes.
module ps2_device #(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_MIN    = 4000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2clk,
    inout  wire        ps2data,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int IC_W = $clog2(IDLE_MIN + 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);
    localparam logic [IC_W-1:0] IC_MAX  = IC_W'(IDLE_MIN);

    typedef enum logic [2:0] {
        IDLE, TX_HI, TX_LO, RX_WAIT, RX_LO, RX_HI, ACK_LO, ACK_HI
    } state_t;

    state_t            state, state_d;
    logic [3:0]        idx, idx_d;
    logic [HC_W-1:0]   hc;
    logic [IC_W-1:0]   idle_cnt;
    logic              sclk_m, sclk, sdata_m, sdata;
    logic              clk_oe, data_oe;
    logic              clk_oe_q1, clk_oe_q2, data_oe_q1, data_oe_q2;
    logic              hold_full;
    logic [7:0]        hold_byte;
    logic [10:0]       frame;
    logic [9:0]        shreg;
    logic              phase_end, host_clk_low, host_data_low;
    logic              load_frame, tx_done, sample, rx_valid_d, rx_err_d;
    logic              tx_bit;

    assign ps2clk   = clk_oe  ? 1'b0 : 1'bz;
    assign ps2data  = data_oe ? 1'b0 : 1'bz;
    assign tx_ready = ~hold_full;
    assign busy     = (state != IDLE);

    assign phase_end = (hc == HC_LAST);
    // The synchronized lines echo our own drive two cycles late; only a low we
    // did not cause two cycles ago belongs to the host.
    assign host_clk_low  = ~sclk  & ~clk_oe_q2;
    assign host_data_low = ~sdata & ~data_oe_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_m  <= 1'b1;
            sclk    <= 1'b1;
            sdata_m <= 1'b1;
            sdata   <= 1'b1;
        end else begin
            sclk_m  <= ps2clk;
            sclk    <= sclk_m;
            sdata_m <= ps2data;
            sdata   <= sdata_m;
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        load_frame = 1'b0;
        tx_done    = 1'b0;
        sample     = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (sclk && host_data_low) begin
                    state_d = RX_WAIT;
                end else if (hold_full && idle_cnt == IC_MAX) begin
                    load_frame = 1'b1;
                    idx_d      = 4'd0;
                    state_d    = TX_HI;
                end
            end
            TX_HI: begin
                if (host_clk_low && idx <= 4'd9) state_d = IDLE;
                else if (phase_end)              state_d = TX_LO;
            end
            TX_LO: begin
                if (phase_end) begin
                    if (idx == 4'd10) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = TX_HI;
                    end
                end
            end
            RX_WAIT: begin
                if (phase_end) begin
                    idx_d   = 4'd0;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                if (phase_end) state_d = RX_HI;
            end
            RX_HI: begin
                if (phase_end) begin
                    sample = 1'b1;
                    if (idx == 4'd9) begin
                        if (sdata) begin
                            state_d = ACK_LO;
                        end else begin
                            rx_err_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = RX_LO;
                    end
                end
            end
            ACK_LO: begin
                if (phase_end) state_d = ACK_HI;
            end
            ACK_HI: begin
                if (phase_end) begin
                    state_d = IDLE;
                    if (^shreg[8:0]) rx_valid_d = 1'b1;
                    else             rx_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A freshly loaded frame always starts with the start bit.
    assign tx_bit = load_frame ? 1'b0 : frame[idx_d];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            hc         <= '0;
            idle_cnt   <= '0;
            hold_full  <= 1'b0;
            clk_oe     <= 1'b0;
            data_oe    <= 1'b0;
            clk_oe_q1  <= 1'b0;
            clk_oe_q2  <= 1'b0;
            data_oe_q1 <= 1'b0;
            data_oe_q2 <= 1'b0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            rx_byte    <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (state_d != state || phase_end) hc <= '0;
            else                               hc <= hc + 1'b1;
            if (sclk && sdata) idle_cnt <= (idle_cnt == IC_MAX) ? idle_cnt : idle_cnt + 1'b1;
            else               idle_cnt <= '0;
            if (tx_done)                     hold_full <= 1'b0;
            else if (tx_valid && !hold_full) hold_full <= 1'b1;
            clk_oe     <= (state_d == TX_LO) || (state_d == RX_LO) || (state_d == ACK_LO);
            data_oe    <= ((state_d == TX_HI || state_d == TX_LO) && !tx_bit) ||
                          (state_d == ACK_LO) || (state_d == ACK_HI);
            clk_oe_q1  <= clk_oe;
            clk_oe_q2  <= clk_oe_q1;
            data_oe_q1 <= data_oe;
            data_oe_q2 <= data_oe_q1;
            rx_valid   <= rx_valid_d;
            rx_err     <= rx_err_d;
            if (rx_valid_d) rx_byte <= shreg[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (tx_valid && !hold_full) hold_byte <= tx_byte;
        if (load_frame) frame <= {1'b1, ~^hold_byte, hold_byte, 1'b0};
        if (sample) shreg[idx] <= sdata;
    end

endmodule

// File: doc/ps2_device.md
# ps2_device

PS/2 device-side (mouse/keyboard emulator) link controller. It generates the PS/2 clock and transmits device-to-host bytes. It also detects host request-to-send, clocks in host-to-device command bytes and acknowledges them. It sits between the open-drain PS/2 pins and device logic, as the counterpart of the team's PS/2 host controller, and serves both as a bench model and as an FPGA-hosted device.

## Interface
- HALF_PERIOD, 2000: clk cycles per PS/2 clock half-period (12.5 kHz at 50 MHz).
- IDLE_MIN, 4000: consecutive cycles with both lines high before a transmit may start.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ps2clk  inout  1  open-drain: driven 0 or released (z).
- ps2data  inout  1  open-drain: driven 0 or released (z).
- tx_byte  in  8  byte to send to host.
- tx_valid  in  1  request; accepted on the cycle `tx_valid && tx_ready`.
- tx_ready  out  1  high when the holding register is empty.
- rx_byte  out  8  last host byte received; held until the next one.
- rx_valid  out  1  one-cycle pulse: good byte received.
- rx_err  out  1  one-cycle pulse: parity or stop error.
- busy  out  1  high in any state other than IDLE.

## Operation
- Line inputs pass through 2-FF synchronizers (sclk, sdata). All decisions use the synchronized values.
- Reset values:
  - both lines released
  - tx_ready=1, rx_valid=0, rx_err=0, rx_byte=0, busy=0
  - state=IDLE, all counters 0
- Half-period counter `hc` counts 0..HALF_PERIOD-1. A "phase end" occurs when hc wraps.
- Idle counter increments while sclk and sdata are both 1, clears otherwise, and saturates at IDLE_MIN.
- States: IDLE, TX_HI, TX_LO, RX_WAIT, RX_LO, RX_HI, ACK_LO, ACK_HI.
- IDLE:
  - sclk=1 and sdata=0 (host RTS) has priority: go to RX_WAIT.
  - Otherwise, if the holding register is full and the idle counter equals IDLE_MIN: load frame, set bit index=0, go to TX_HI.
  - sclk=0 (inhibit): stay in IDLE.
- Transmit frame (11 bits, LSB first): start 0, data[7:0], odd parity (~^data), stop 1.
  - TX_HI: clock released. Data line drives 0 when frame bit = 0, else released, set on entry. At phase end go to TX_LO.
  - TX_LO: clock driven 0 for one half-period (host samples on the falling edge). At phase end:
    - if bit index=10: release both lines, empty the holding register (tx_ready=1), go to IDLE
    - else: index+1, go to TX_HI
  - Inhibit: sclk=0 on any cycle of TX_HI with index≤9 aborts. Release both lines, go to IDLE, keep the holding register full, retransmit the whole frame later. Inhibit during index 10 is ignored.
- Receive (host to device):
  - RX_WAIT: wait one half-period, then go to RX_LO with index=0.
  - RX_LO: clock driven 0 for one half-period.
  - RX_HI: clock released for one half-period. On its last cycle, sample sdata into shift register[index].
  - The sequence is 10 cells: data0..7, parity, stop.
  - After the stop sample:
    - stop=1: go to ACK_LO. Data is driven 0 through ACK_LO and ACK_HI, then released; return to IDLE.
    - stop=0: pulse rx_err, release lines, go to IDLE with no ack.
  - Leaving ACK_HI: if the parity over data+parity is odd, update rx_byte and pulse rx_valid; else pulse rx_err (rx_byte unchanged).
- tx_valid may be accepted in any state. The byte waits in the holding register; a receive in progress delays the transmit.

## Timing
- Synchronizer latency is 2 cycles. Inhibit and RTS response is ≤3 cycles after the pin changes.
- Device clock period is 2×HALF_PERIOD cycles at 50% duty.
- Transmit: the first data edge occurs 1 cycle after the IDLE→TX_HI decision. A frame lasts 22×HALF_PERIOD cycles. tx_ready rises on the cycle after the last TX_LO phase end.
- Receive: 10 data cells plus 1 ack cell plus the RX_WAIT half-period, i.e. 23×HALF_PERIOD cycles. rx_valid/rx_err pulse on the cycle after ACK_HI ends.
- The device never drives a line high. Reset asserted mid-frame releases both lines asynchronously.

## Test plan
- Bench uses HALF_PERIOD=4, IDLE_MIN=8.
- Transmit 0xFA, host model samples on falling sclk -> 11 bits 0,0,1,0,1,1,1,1,1,1,1 (parity 1); 11 falling edges, each low for 4 cycles; tx_ready returns 1.
- Host RTS then sends 0xF4 with parity 0 -> rx_byte=0xF4, one rx_valid pulse, data low during the 11th device clock, no rx_err.
- Host sends 0xF4 with parity 1 -> ack still given, rx_err pulse, rx_byte keeps its previous value, rx_valid stays 0.
- Host pulls clock low during bit 4 of a 0xAA transmit -> both lines released within 3 cycles, tx_ready stays 0; after release plus IDLE_MIN, the full 0xAA frame is resent from the start bit.
- tx_valid(0x55) on the same cycle the host RTS arrives -> receive completes first, then 0x55 is transmitted; stop=0 from host -> rx_err, no ack.
- Assert rst mid-receive -> lines released immediately, all outputs at reset values, next RTS handled normally.
